sample_demultiplexer: RTL
=========================

// Module: sample_demultiplexer
// PURPOSE
//  Receive-side counterpart of the FX2 sample byte stream: accepts bytes over the
//  data_avail/data/data_accepted byte handshake and reassembles them into
//  48-bit timetag samples (44-bit timer word + 4 laser_en bits).
//  Used in loopback/self-test builds and for host-emulation benches.
//  Presents complete samples on a rdy/ack interface matching sample_fifo consumers.
// PARAMETERS
//  SAMPLE_BYTES    6     bytes per sample; sample width = 8*SAMPLE_BYTES
//  TIMEOUT_CYCLES  1024  idle cycles before a partial sample is discarded (SAMPLE_DEMUX_TIMEOUT_EN only)
// PORTS
//  clk           in   1       single clock; all logic on posedge
//  rst_n         in   1       asynchronous active-low reset
//  byte_avail    in   1       upstream byte valid
//  byte_data     in   8       upstream byte
//  byte_ack      out  1       byte accepted this cycle (combinational)
//  flush         in   1       synchronous: drop any partial sample
//  sample_rdy    out  1       complete sample held in output register
//  sample        out  8*SAMPLE_BYTES  assembled sample
//  sample_ack    in   1       consumer takes sample this cycle
//  byte_index    out  3       bytes collected toward current sample (0..SAMPLE_BYTES-1)
//  drop_count    out  8       partial samples discarded (flush/timeout), saturating
// BEHAVIOUR
//  Reset: byte_index=0, assembly reg=0, sample=0, sample_rdy=0, drop_count=0.
//  Byte order: LSB first; byte k lands in sample[8k+7:8k]; byte 0 = sample[7:0].
//  Byte transfer occurs when byte_avail && byte_ack on a clk edge.
//  byte_ack = byte_avail && !flush && !(byte_index==SAMPLE_BYTES-1 && sample_rdy && !sample_ack).
//   -> stalls only when the final byte would complete while the output reg is occupied.
//  Bytes 0..N-2 write the assembly reg and increment byte_index.
//  Final byte (index N-1): output reg <= {byte_data, assembly[8N-9:0]}, sample_rdy<=1,
//   byte_index<=0. Latency: sample_rdy high the cycle after the final byte transfer.
//  sample_rdy && sample_ack with no completing byte: sample_rdy<=0, sample unchanged.
//  sample_ack while sample_rdy and final byte transfer in same cycle: new sample loads,
//   sample_rdy stays 1 (back-to-back, no bubble). sample_ack with sample_rdy=0 ignored.
//  flush: byte_index<=0; if byte_index!=0, drop_count++ (saturate at 255);
//   the output register and sample_rdy are unaffected; no byte accepted that cycle.
//  Assembly reg bytes beyond byte_index are don't-care; they are never exposed.
//  rst_n asserted mid-sample: everything returns to its reset value immediately;
//   the partial sample is lost and is not counted.
// CONFIGURATION
//  SAMPLE_DEMUX_TIMEOUT_EN defined: idle counter clears on every byte transfer and
//   counts while byte_index!=0. When it reaches TIMEOUT_CYCLES-1, byte_index<=0 and
//   drop_count++. A flush in the same cycle counts as one drop only.
//  Not defined: no idle counter; a partial sample waits indefinitely.
// STRUCTURE
//  Shared package timetag_pkg: SAMPLE_BYTES_DEF=6, SAMPLE_W=48, TIMER_W=44, LASER_W=4.
//  Single module; no sub-module. Timeout counter lives in an `ifdef block.
// TESTING
//  1 bytes 0x01..0x06 back-to-back, sample_ack tied 1 -> sample=48'h060504030201,
//    sample_rdy for 1 cycle.
//  2 two samples streamed, sample_ack held 0 -> byte_ack low on 12th byte until ack;
//    1st sample stable; 2nd loads on the ack cycle with no bubble.
//  3 3 bytes then flush -> byte_index=0, drop_count=1; next 6 bytes 0xA0..0xA5
//    -> sample=48'hA5A4A3A2A1A0.
//  4 (TIMEOUT_EN, TIMEOUT_CYCLES=16) 2 bytes then 16 idle cycles -> byte_index=0,
//    drop_count=1; with the macro undefined -> byte_index stays 2.
//  5 rst_n low during byte 4 -> all outputs 0; a fresh 6-byte sample assembles correctly.
//  6 260 flushes of partial samples -> drop_count saturates at 255.

Source files
------------

// File: rtl/timetag_pkg.sv
// Shared timetag definitions: sample geometry and the packed timetag sample layout.
package timetag_pkg;

    localparam int unsigned SAMPLE_BYTES_DEF = 6;
    localparam int unsigned SAMPLE_W         = 8 * SAMPLE_BYTES_DEF;
    localparam int unsigned TIMER_W          = 44;
    localparam int unsigned LASER_W          = 4;

    typedef struct packed {
        logic [LASER_W-1:0] laser_en;
        logic [TIMER_W-1:0] timer;
    } timetag_t;

    // Saturating 8-bit increment used by the drop counter.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/sample_demultiplexer_if.sv
// Byte-in / sample-out bus of the sample demultiplexer; master = upstream/consumer side.
interface sample_demultiplexer_if #(
    parameter int unsigned SAMPLE_BYTES = timetag_pkg::SAMPLE_BYTES_DEF
);
    logic                      byte_avail;
    logic [7:0]                byte_data;
    logic                      byte_ack;
    logic                      flush;
    logic                      sample_rdy;
    logic [8*SAMPLE_BYTES-1:0] sample;
    logic                      sample_ack;
    logic [2:0]                byte_index;
    logic [7:0]                drop_count;

    modport master (
        output byte_avail, byte_data, flush, sample_ack,
        input  byte_ack, sample_rdy, sample, byte_index, drop_count
    );

    modport slave (
        input  byte_avail, byte_data, flush, sample_ack,
        output byte_ack, sample_rdy, sample, byte_index, drop_count
    );
endinterface

// File: rtl/sample_demultiplexer.sv
// Reassembles an LSB-first byte stream into SAMPLE_BYTES-wide timetag samples.
// Optional partial-sample timeout is enabled by defining SAMPLE_DEMUX_TIMEOUT_EN.
module sample_demultiplexer
    import timetag_pkg::*;
#(
    parameter int unsigned SAMPLE_BYTES   = SAMPLE_BYTES_DEF,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                 clk,
    input  logic                 rst_n,
    sample_demultiplexer_if.slave bus
);

    localparam int unsigned SW   = 8 * SAMPLE_BYTES;
    localparam int unsigned AW   = 8 * (SAMPLE_BYTES - 1);
    localparam int unsigned LAST = SAMPLE_BYTES - 1;

    logic [2:0]    idx_q;
    logic [AW-1:0] asm_q;
    logic [SW-1:0] sample_q;
    logic          rdy_q;
    logic [7:0]    drop_q;

    logic last_c;
    logic byte_ack_c;
    logic xfer_c;
    logic timeout_c;

    // Stall only when the completing byte would overwrite an unconsumed sample.
    assign last_c     = (idx_q == 3'(LAST));
    assign byte_ack_c = bus.byte_avail && !bus.flush &&
                        !(last_c && rdy_q && !bus.sample_ack);
    assign xfer_c     = bus.byte_avail && byte_ack_c;

`ifdef SAMPLE_DEMUX_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES) + 1;

    logic [CW-1:0] idle_q;

    assign timeout_c = (idx_q != 3'd0) && (idle_q == CW'(TIMEOUT_CYCLES - 1));

    // Idle counter runs only while a partial sample is pending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_q <= '0;
        end else if (xfer_c || bus.flush || timeout_c || idx_q == 3'd0) begin
            idle_q <= '0;
        end else begin
            idle_q <= idle_q + CW'(1);
        end
    end
`else
    assign timeout_c = 1'b0;
`endif

    // Byte assembly, partial-sample discard and drop accounting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q    <= 3'd0;
            asm_q    <= '0;
            sample_q <= '0;
            drop_q   <= 8'd0;
        end else if (bus.flush) begin
            idx_q <= 3'd0;
            if (idx_q != 3'd0) begin
                drop_q <= sat_inc8(drop_q);
            end
        end else if (xfer_c) begin
            if (last_c) begin
                sample_q <= {bus.byte_data, asm_q};
                idx_q    <= 3'd0;
            end else begin
                asm_q[8*int'(idx_q) +: 8] <= bus.byte_data;
                idx_q                     <= idx_q + 3'd1;
            end
        end else if (timeout_c) begin
            idx_q  <= 3'd0;
            drop_q <= sat_inc8(drop_q);
        end
    end

    // Output-register occupancy; a completing byte wins over a same-cycle ack.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_q <= 1'b0;
        end else if (xfer_c && last_c) begin
            rdy_q <= 1'b1;
        end else if (bus.sample_ack) begin
            rdy_q <= 1'b0;
        end
    end

    assign bus.byte_ack   = byte_ack_c;
    assign bus.sample_rdy = rdy_q;
    assign bus.sample     = sample_q;
    assign bus.byte_index = idx_q;
    assign bus.drop_count = drop_q;

endmodule
